// File: rtl/as2650_sram_ctrl.sv
// as2650_sram_ctrl: bus-side controller for the AS2650 512x8 SRAM macro (2-cycle registered reads).
// Define AS2650_SRAM_CLEAR_EN to write CLR_VALUE to every location after reset before granting access.
module as2650_sram_ctrl #(
    parameter int unsigned       ADDR_W    = 9,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] bmask,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ram_cen,
    output logic              ram_gwen,
    output logic [DATA_W-1:0] ram_wen,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
`ifdef AS2650_SRAM_CLEAR_EN
    localparam logic [1:0] ST_CLEAR = 2'd3;
    localparam logic [1:0] ST_RESET = ST_CLEAR;
`else
    localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic              w_bus;
    logic              w_wr;
    logic              w_rd;
    logic              w_clr;

    // Qualifying with rst_n makes every output show its reset value while reset is held.
    assign w_bus = rst_n & ((r_state == ST_IDLE) | (r_state == ST_RESP));
    assign w_wr  = w_bus & req & we;
    assign w_rd  = w_bus & req & ~we;

`ifdef AS2650_SRAM_CLEAR_EN
    logic [ADDR_W-1:0] r_clr_cnt;

    assign w_clr = rst_n & (r_state == ST_CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
        end
    end
`else
    logic [DATA_W-1:0] w_unused_clr;

    assign w_clr        = 1'b0;
    assign w_unused_clr = CLR_VALUE;
`endif

    always_comb begin
        ram_cen  = 1'b1;
        ram_gwen = 1'b1;
        ram_wen  = '1;
        ram_a    = '0;
        ram_d    = '0;
        if (w_bus) begin
            ram_a    = addr;
            ram_d    = wdata;
            ram_cen  = ~(w_rd | (w_wr & (bmask != '0)));
            ram_gwen = ~w_wr;
            if (w_wr) begin
                ram_wen = ~bmask;
            end
        end
`ifdef AS2650_SRAM_CLEAR_EN
        if (w_clr) begin
            ram_cen  = 1'b0;
            ram_gwen = 1'b0;
            ram_wen  = '0;
            ram_a    = r_clr_cnt;
            ram_d    = CLR_VALUE;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: w_state_nxt = w_rd ? ST_RD : ST_IDLE;
            ST_RD:            w_state_nxt = ST_RESP;
`ifdef AS2650_SRAM_CLEAR_EN
            ST_CLEAR:         w_state_nxt = (&r_clr_cnt) ? ST_IDLE : ST_CLEAR;
`endif
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RESET;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_RD) begin
                r_rdata <= ram_q;
            end
        end
    end

    assign ready  = w_bus;
    assign rvalid = (r_state == ST_RESP);
    assign rdata  = r_rdata;
    assign busy   = w_clr;

endmodule
